lipsi_ctrl: RTL

- Fetch/decode/sequencing unit for the 8-bit Lipsi accumulator processor; sits directly upstream of the ALU.
- Owns the PC and instruction register, and drives instruction-memory and data-memory addresses.
- Drives the ALU's alu_ctrl and rd_data operand, and the accumulator write enable.
- The accumulator register is external; its value returns on acc_out. Registers r0..r15 are dmem[0x00..0x0F].

---
 rtl/lipsi_pkg.sv | 49 ++++
 rtl/lipsi_decode.sv | 44 ++++
 rtl/lipsi_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/lipsi_pkg.sv
// Shared types and encodings for the Lipsi fetch/decode/sequencing unit.
package lipsi_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_IND,
        S_IND_ST,
        S_IMM,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_ALU_REG,
        C_ST,
        C_BRL,
        C_LDIND,
        C_STIND,
        C_IMM,
        C_SHIFT,
        C_NOP,
        C_EXIT
    } op_class_t;

    localparam logic [3:0] OP_ST    = 4'h8;
    localparam logic [3:0] OP_BRL   = 4'h9;
    localparam logic [3:0] OP_LDIND = 4'hA;
    localparam logic [3:0] OP_STIND = 4'hB;
    localparam logic [3:0] OP_ALUI  = 4'hC;
    localparam logic [3:0] OP_BR    = 4'hD;
    localparam logic [3:0] OP_SH    = 4'hE;
    localparam logic [3:0] OP_IO    = 4'hF;
    localparam logic [7:0] EXIT     = 8'hFF;

    localparam logic [3:0] ALU_HOLD = 4'h0;
    localparam logic [3:0] ALU_LD   = 4'hF;

    // cc=01 is reserved and never branches
    function automatic logic br_taken(input logic [1:0] cc, input logic acc_zero);
        case (cc)
            2'b00:   return 1'b1;
            2'b10:   return acc_zero;
            2'b11:   return !acc_zero;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lipsi_decode.sv
// Pure combinational classification of an instruction byte into op class and follow-on state.
module lipsi_decode
    import lipsi_pkg::*;
(
    input  logic [7:0] instr,
    output op_class_t  op_class,
    output state_t     next_state
);

    always_comb begin
        op_class   = C_NOP;
        next_state = S_FETCH;
        if (!instr[7]) begin
            op_class   = C_ALU_REG;
            next_state = S_EXEC;
        end else begin
            case (instr[7:4])
                OP_ST:    op_class = C_ST;
                OP_BRL:   op_class = C_BRL;
                OP_LDIND: begin
                    op_class   = C_LDIND;
                    next_state = S_IND;
                end
                OP_STIND: begin
                    op_class   = C_STIND;
                    next_state = S_IND_ST;
                end
                OP_ALUI, OP_BR: begin
                    op_class   = C_IMM;
                    next_state = S_IMM;
                end
                OP_SH:    op_class = C_SHIFT;
                OP_IO: begin
                    if (instr == EXIT) begin
                        op_class   = C_EXIT;
                        next_state = S_HALT;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/lipsi_ctrl.sv
// Lipsi control unit: PC, instruction register, sequencing FSM and ALU/memory strobes.
module lipsi_ctrl
    import lipsi_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              DATA_W   = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [7:0]        dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              dmem_we,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic [DATA_W-1:0] acc_out,
    output logic              acc_we,
    output logic [DATA_W-1:0] rd_data,
    output logic [3:0]        alu_ctrl,
    output logic              halted
);

    state_t            state, state_next;
    logic [PC_W-1:0]   pc, pc_next, pc_inc;
    logic [DATA_W-1:0] ir, ir_next;
    op_class_t         dec_class;
    state_t            dec_state;
    logic              unused_ir;

    assign pc_inc    = pc + PC_W'(1);
    assign unused_ir = ir[3];

    lipsi_decode u_decode (
        .instr      (imem_rdata[7:0]),
        .op_class   (dec_class),
        .next_state (dec_state)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            ir    <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            ir    <= ir_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_next    = ir;
        imem_addr  = pc;
        dmem_addr  = '0;
        dmem_wdata = acc_out;
        dmem_we    = 1'b0;
        acc_we     = 1'b0;
        rd_data    = dmem_rdata;
        alu_ctrl   = ALU_HOLD;
        halted     = 1'b0;

        case (state)
            S_FETCH: begin
                pc_next    = pc_inc;
                state_next = S_DECODE;
            end

            // Decode acts on the ROM output directly; ir only serves the later states.
            S_DECODE: begin
                ir_next    = imem_rdata;
                state_next = dec_state;
                dmem_addr  = {4'h0, imem_rdata[3:0]};
                case (dec_class)
                    C_ST:    dmem_we = 1'b1;
                    C_BRL: begin
                        dmem_wdata = DATA_W'(pc);
                        dmem_we    = 1'b1;
                        pc_next    = PC_W'(acc_out);
                    end
                    C_IMM:   pc_next = pc_inc;
                    C_SHIFT: begin
                        alu_ctrl = {2'b01, imem_rdata[1:0]};
                        acc_we   = 1'b1;
                    end
                    default: ;
                endcase
            end

            S_EXEC: begin
                acc_we     = 1'b1;
                alu_ctrl   = (ir[7:4] == OP_LDIND) ? ALU_LD : {1'b1, ir[6:4]};
                state_next = S_FETCH;
            end

            S_IND: begin
                dmem_addr  = dmem_rdata[7:0];
                state_next = S_EXEC;
            end

            S_IND_ST: begin
                dmem_addr  = dmem_rdata[7:0];
                dmem_we    = 1'b1;
                state_next = S_FETCH;
            end

            S_IMM: begin
                state_next = S_FETCH;
                if (ir[7:4] == OP_ALUI) begin
                    rd_data  = imem_rdata;
                    alu_ctrl = {1'b1, ir[2:0]};
                    acc_we   = 1'b1;
                end else if (br_taken(ir[1:0], acc_out == '0)) begin
                    pc_next = PC_W'(imem_rdata);
                end
            end

            S_HALT: halted = 1'b1;

            default: state_next = S_FETCH;
        endcase
    end

endmodule
